pwl_coef_fetch: RTL

PWL_COEF_FETCH -- requirements
Module: pwl_coef_fetch

---
 rtl/pwl_pkg.sv | 16 +
 rtl/pwl_coef_table.sv | 40 ++++
 rtl/pwl_coef_fetch.sv | 123 ++++++++++++
 3 files changed

// File: rtl/pwl_pkg.sv
// Shared state encoding and default widths for the piecewise-linear coefficient fetch block.
package pwl_pkg;

  localparam int X_DW_DEF = 16;
  localparam int X_FL_DEF = 11;
  localparam int A_DW_DEF = 16;
  localparam int B_DW_DEF = 16;
  localparam int SEGW_DEF = 4;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } pwl_state_t;

endpackage

// File: rtl/pwl_coef_table.sv
// Segment coefficient store: synchronous write, asynchronous read, synchronous clear of every entry.
module pwl_coef_table
  import pwl_pkg::*;
#(
  parameter int aDW  = A_DW_DEF,
  parameter int bDW  = B_DW_DEF,
  parameter int SEGW = SEGW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [SEGW-1:0] waddr,
  input  logic [aDW-1:0]  wa,
  input  logic [bDW-1:0]  wb,
  input  logic [SEGW-1:0] raddr,
  output logic [aDW-1:0]  rd_a,
  output logic [bDW-1:0]  rd_b
);

  localparam int SEG = 2 ** SEGW;

  logic [aDW-1:0] a_mem [SEG];
  logic [bDW-1:0] b_mem [SEG];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SEG; i++) begin
        a_mem[i] <= '0;
        b_mem[i] <= '0;
      end
    end else if (we) begin
      a_mem[waddr] <= wa;
      b_mem[waddr] <= wb;
    end
  end

  assign rd_a = a_mem[raddr];
  assign rd_b = b_mem[raddr];

endmodule

// File: rtl/pwl_coef_fetch.sv
// Maps each signed sample to its segment and pairs it with that segment's {a,b}
// through a two-stage elastic pipeline; the table is reloadable only after a drain.
module pwl_coef_fetch
  import pwl_pkg::*;
#(
  parameter int xDW  = X_DW_DEF,
  parameter int xFL  = X_FL_DEF,
  parameter int aDW  = A_DW_DEF,
  parameter int bDW  = B_DW_DEF,
  parameter int SEGW = SEGW_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_we,
  input  logic [SEGW-1:0]       cfg_addr,
  input  logic [aDW-1:0]        cfg_a,
  input  logic [bDW-1:0]        cfg_b,
  input  logic                  cfg_start,
  input  logic                  cfg_done,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic signed [xDW-1:0] in_x,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic signed [xDW-1:0] out_x,
  output logic signed [aDW-1:0] out_a,
  output logic signed [bDW-1:0] out_b,
  output logic                  loaded
);

  // The fraction width only matters downstream; here it merely has to fit inside the sample.
  if (SEGW < 2 || SEGW >= xDW || xFL >= xDW) begin : g_bad_params
    $error("pwl_coef_fetch: unsupported parameter combination");
  end

  pwl_state_t state, state_nxt;

  logic                  s1_valid;
  logic signed [xDW-1:0] s1_x;
  logic [SEGW-1:0]       s1_idx;
  logic                  s2_valid;
  logic [SEGW-1:0]       in_idx;
  logic [aDW-1:0]        tbl_a;
  logic [bDW-1:0]        tbl_b;
  logic                  s2_ready;
  logic                  s1_adv;
  logic                  accept;
  logic                  tbl_we;

  // Offset-binary top bits: the most negative sample lands in segment 0.
  assign in_idx   = {~in_x[xDW-1], in_x[xDW-2 : xDW-SEGW]};

  assign s2_ready  = !s2_valid || out_ready;
  assign s1_adv    = s1_valid && s2_ready;
  assign in_ready  = (state == RUN) && (!s1_valid || s2_ready);
  assign accept    = in_valid && in_ready;
  assign tbl_we    = (state == LOAD) && cfg_we;
  assign loaded    = (state == RUN);
  assign out_valid = s2_valid;

  pwl_coef_table #(
    .aDW  (aDW),
    .bDW  (bDW),
    .SEGW (SEGW)
  ) u_table (
    .clk   (clk),
    .rst   (rst),
    .we    (tbl_we),
    .waddr (cfg_addr),
    .wa    (cfg_a),
    .wb    (cfg_b),
    .raddr (s1_idx),
    .rd_a  (tbl_a),
    .rd_b  (tbl_b)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (cfg_done) state_nxt = RUN;
      RUN:     if (cfg_start) state_nxt = DRAIN;
      DRAIN:   if (!s1_valid && !s2_valid) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_x     <= '0;
      s1_idx   <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_x     <= in_x;
      s1_idx   <= in_idx;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // Coefficients are captured at the S1->S2 transfer and held through any output stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      out_x    <= '0;
      out_a    <= '0;
      out_b    <= '0;
    end else if (s1_adv) begin
      s2_valid <= 1'b1;
      out_x    <= s1_x;
      out_a    <= $signed(tbl_a);
      out_b    <= $signed(tbl_b);
    end else if (out_ready) begin
      s2_valid <= 1'b0;
    end
  end

endmodule
